// File: rtl/soft_branch_metric_unit_if.sv
// Handshake/bus bundle for the soft branch metric unit: symbol input side
// (demapper/depuncturer) and metric output side (add-compare-select).
interface soft_branch_metric_unit_if #(
  parameter int N_OUT  = 2,
  parameter int SOFT_W = 3,
  parameter int CNT_W  = 16
);
  localparam int BM_W = $clog2(N_OUT * ((1 << SOFT_W) - 1) + 1);
  localparam int N_CW = 1 << N_OUT;

  logic                    i_valid;
  logic                    o_ready;
  logic [N_OUT*SOFT_W-1:0] i_data;
  logic [N_OUT-1:0]        i_erase;
  logic                    i_last;

  logic                    o_valid;
  logic                    i_ready;
  logic [N_CW*BM_W-1:0]    o_metric;
  logic [N_OUT-1:0]        o_min_idx;
  logic                    o_last;
  logic [CNT_W-1:0]        o_sym_cnt;

  // Drives symbols in and accepts metric bundles.
  modport master (
    output i_valid, i_data, i_erase, i_last, i_ready,
    input  o_ready, o_valid, o_metric, o_min_idx, o_last, o_sym_cnt
  );

  // The metric unit itself.
  modport slave (
    input  i_valid, i_data, i_erase, i_last, i_ready,
    output o_ready, o_valid, o_metric, o_min_idx, o_last, o_sym_cnt
  );
endinterface

// File: rtl/soft_branch_metric_unit.sv
// Two-stage pipelined branch metric unit: per-bit distances (soft or hard,
// with erasures) in stage 1, all 2^N_OUT codeword sums plus arg-min in
// stage 2. Valid/ready handshake with a frame-aware symbol counter.
// Reset release is assumed to be synchronised upstream; assertion is async.
module soft_branch_metric_unit #(
  parameter int N_OUT  = 2,
  parameter int SOFT_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_flush,
  input  logic i_hard_mode,
  soft_branch_metric_unit_if.slave bus
);
  localparam int SMAX = (1 << SOFT_W) - 1;
  localparam int N_CW = 1 << N_OUT;
  localparam int BM_W = $clog2(N_OUT * SMAX + 1);

  logic advance;
  logic accept;

  logic [N_OUT-1:0][SOFT_W-1:0] d0_nx, d1_nx;
  logic [N_OUT-1:0][SOFT_W-1:0] s1_d0, s1_d1;
  logic                         s1_valid, s1_last;

  logic [N_CW-1:0][BM_W-1:0]    sum_c;
  logic [BM_W-1:0]              best_c;
  logic [N_OUT-1:0]             min_c;

  logic [N_CW-1:0][BM_W-1:0]    metric_q;
  logic [N_OUT-1:0]             min_q;
  logic                         o_valid_q, o_last_q;
  logic [CNT_W-1:0]             cnt_q;

  // A full output stage only moves when downstream takes it.
  assign advance     = i_en && (!o_valid_q || bus.i_ready);
  assign accept      = bus.i_valid && advance && !i_flush;
  assign bus.o_ready = advance;

  // Per-bit distances to '0' and '1', with mode and erasure already applied.
  always_comb begin
    d0_nx = '0;
    d1_nx = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (bus.i_erase[j]) begin
        d0_nx[j] = '0;
        d1_nx[j] = '0;
      end else if (i_hard_mode) begin
        d0_nx[j] = bus.i_data[j*SOFT_W + SOFT_W-1] ? SOFT_W'(1) : '0;
        d1_nx[j] = bus.i_data[j*SOFT_W + SOFT_W-1] ? '0 : SOFT_W'(1);
      end else begin
        d0_nx[j] = bus.i_data[j*SOFT_W +: SOFT_W];
        d1_nx[j] = SOFT_W'(SMAX) - bus.i_data[j*SOFT_W +: SOFT_W];
      end
    end
  end

  // Codeword sums from stage 1 and the lowest-index minimum.
  always_comb begin
    sum_c  = '0;
    best_c = '0;
    min_c  = '0;
    for (int k = 0; k < N_CW; k++) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (((k >> j) & 1) == 1)
          sum_c[k] = sum_c[k] + BM_W'(s1_d1[j]);
        else
          sum_c[k] = sum_c[k] + BM_W'(s1_d0[j]);
      end
    end
    best_c = sum_c[0];
    for (int k = 1; k < N_CW; k++) begin
      if (sum_c[k] < best_c) begin
        best_c = sum_c[k];
        min_c  = N_OUT'(k);
      end
    end
  end

  // Stage 1: capture per-bit distances with the symbol's valid and last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_d0    <= '0;
      s1_d1    <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        s1_valid <= 1'b0;
        s1_last  <= 1'b0;
      end else if (advance) begin
        s1_valid <= bus.i_valid;
        s1_last  <= bus.i_valid && bus.i_last;
        s1_d0    <= d0_nx;
        s1_d1    <= d1_nx;
      end
    end
  end

  // Stage 2: register sums and arg-min; held while the bundle is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      metric_q  <= '0;
      min_q     <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        o_valid_q <= 1'b0;
        o_last_q  <= 1'b0;
      end else if (advance) begin
        o_valid_q <= s1_valid;
        o_last_q  <= s1_last;
        metric_q  <= sum_c;
        min_q     <= min_c;
      end
    end
  end

  // Symbol counter: counts accepts, restarts after a frame's last symbol.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_en) begin
      if (i_flush)
        cnt_q <= '0;
      else if (accept)
        cnt_q <= bus.i_last ? '0 : cnt_q + 1'b1;
    end
  end

  assign bus.o_valid   = o_valid_q;
  assign bus.o_last    = o_last_q;
  assign bus.o_metric  = metric_q;
  assign bus.o_min_idx = min_q;
  assign bus.o_sym_cnt = cnt_q;
endmodule
